// File: rtl/cm0_dap_cdc_req_ctrl.sv
// Four-phase request/acknowledge sequencer feeding a bank of CDC send registers.
// Two local requesters share the bank via round-robin arbitration.
module cm0_dap_cdc_req_ctrl #(
    parameter int DW = 32
) (
    input  logic          REGCLK,
    input  logic          REGRESETn,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [DW-1:0] DATA0,
    input  logic [DW-1:0] DATA1,
    output logic          GNT0,
    output logic          GNT1,
    output logic          CDCDATAEN,
    output logic [DW-1:0] CDCDATA,
    output logic          CDCREQEN,
    output logic          CDCREQDI,
    input  logic          CDCACK,
    output logic          BUSY,
    output logic          DONE,
    output logic          SRCID
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RISE  = 3'd2,
        S_WACKH = 3'd3,
        S_FALL  = 3'd4,
        S_WACKL = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_srcid;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_dataen;
    logic [DW-1:0] r_data;
    logic          r_reqen;
    logic          r_reqdi;
    logic          r_busy;
    logic          r_done;

    logic          w_start;
    logic          w_winner;

    // A stale acknowledge still high from the previous handshake blocks a new start.
    assign w_start  = !CDCACK && (REQ0 || REQ1);
    assign w_winner = (REQ0 && REQ1) ? ~r_last : REQ1;

    always_ff @(posedge REGCLK or negedge REGRESETn) begin
        if (!REGRESETn) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_srcid  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_dataen <= 1'b0;
            r_data   <= '0;
            r_reqen  <= 1'b0;
            r_reqdi  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_dataen <= 1'b0;
            r_data   <= '0;
            r_reqen  <= 1'b0;
            r_reqdi  <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_LOAD;
                        r_srcid  <= w_winner;
                        r_last   <= w_winner;
                        r_dataen <= 1'b1;
                        r_data   <= w_winner ? DATA1 : DATA0;
                        r_gnt0   <= ~w_winner;
                        r_gnt1   <= w_winner;
                        r_busy   <= 1'b1;
                    end
                end
                // Data registers load one cycle before the request bit can move.
                S_LOAD: begin
                    r_state <= S_RISE;
                    r_reqen <= 1'b1;
                    r_reqdi <= 1'b1;
                end
                S_RISE: begin
                    r_state <= S_WACKH;
                end
                S_WACKH: begin
                    if (CDCACK) begin
                        r_state <= S_FALL;
                        r_reqen <= 1'b1;
                        r_reqdi <= 1'b0;
                    end
                end
                S_FALL: begin
                    r_state <= S_WACKL;
                end
                S_WACKL: begin
                    if (!CDCACK) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT0      = r_gnt0;
    assign GNT1      = r_gnt1;
    assign CDCDATAEN = r_dataen;
    assign CDCDATA   = r_data;
    assign CDCREQEN  = r_reqen;
    assign CDCREQDI  = r_reqdi;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign SRCID     = r_srcid;

`ifdef ARM_ASSERT_ON
    a_inputs_known: assert property (@(posedge REGCLK) disable iff (!REGRESETn)
        !$isunknown({REQ0, REQ1, CDCACK}));
`endif

endmodule

// File: tb/tb_cm0_dap_cdc_req_ctrl.sv
// Scoreboard bench for cm0_dap_cdc_req_ctrl: a transaction-level reference model
// predicts grant/request/done events, and a monitor pops and compares them.
module tb_cm0_dap_cdc_req_ctrl;

    localparam int DW = 32;

    typedef enum int {EV_GNT, EV_REQHI, EV_REQLO, EV_DONE} evKind_t;
    typedef struct {
        int            cyc;
        evKind_t       kind;
        int            id;
        logic [DW-1:0] data;
    } expEv_t;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          reqV [2];
    logic [DW-1:0] dataV [2];
    logic          gnt0, gnt1, cdcDataEn, cdcReqEn, cdcReqDi, busy, done, srcId;
    logic [DW-1:0] cdcData;
    logic          cdcAck;

    logic          ackForce = 1'b0;
    logic          ackForceVal = 1'b0;
    logic [1:0]    ackSel = 2'd1;
    logic          reqReg;
    logic [3:0]    ackPipe;

    int            reqMode [2];
    logic [DW-1:0] fixedData [2];
    expEv_t        expQ [$];
    int            modelLast;
    bit            modelActive;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cm0_dap_cdc_req_ctrl #(.DW(DW)) dut (
        .REGCLK    (clk),
        .REGRESETn (rstN),
        .REQ0      (reqV[0]),
        .REQ1      (reqV[1]),
        .DATA0     (dataV[0]),
        .DATA1     (dataV[1]),
        .GNT0      (gnt0),
        .GNT1      (gnt1),
        .CDCDATAEN (cdcDataEn),
        .CDCDATA   (cdcData),
        .CDCREQEN  (cdcReqEn),
        .CDCREQDI  (cdcReqDi),
        .CDCACK    (cdcAck),
        .BUSY      (busy),
        .DONE      (done),
        .SRCID     (srcId)
    );

    // Destination side: the request send register followed by a delay line
    // standing in for the crossing and the acknowledge synchroniser.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            reqReg  <= 1'b0;
            ackPipe <= '0;
        end else begin
            if (cdcReqEn) reqReg <= cdcReqDi;
            ackPipe <= {ackPipe[2:0], reqReg};
        end
    end

    assign cdcAck = ackForce ? ackForceVal : ackPipe[ackSel];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s at cycle %0d: wait budget expired", name, cyc);
    endtask

    function automatic logic gntOf(input int i);
        return (i == 0) ? gnt0 : gnt1;
    endfunction

    // Mode 0 idle, 1 random requests, 2 continuously high, 3 a single request.
    task automatic applyStimulus(input int i);
        bit shotDone = 0;
        reqV[i]  = 1'b0;
        dataV[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reqMode[i] != 3) shotDone = 0;
            case (reqMode[i])
                0: reqV[i] = 1'b0;
                1: begin
                    if (reqV[i] && gntOf(i)) reqV[i] = 1'b0;
                    else if (!reqV[i] && $urandom_range(3) == 0) begin
                        reqV[i]  = 1'b1;
                        dataV[i] = $urandom;
                    end
                end
                2: begin
                    reqV[i]  = 1'b1;
                    dataV[i] = fixedData[i];
                end
                default: begin
                    if (reqV[i] && gntOf(i)) begin
                        reqV[i]  = 1'b0;
                        shotDone = 1;
                    end else if (!reqV[i] && !shotDone) begin
                        reqV[i]  = 1'b1;
                        dataV[i] = fixedData[i];
                    end
                end
            endcase
        end
    endtask

    initial applyStimulus(0);
    initial applyStimulus(1);

    // Reference model: arbitrate when idle with a low ack, then follow the
    // handshake timing rules as seen through CDCACK.
    initial begin : refModel
        int c;
        int winner;
        bit abort;
        modelLast   = 1;
        modelActive = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                expQ.delete();
                modelLast   = 1;
                modelActive = 0;
                continue;
            end
            if (cdcAck || !(reqV[0] || reqV[1])) continue;
            if (reqV[0] && reqV[1]) winner = 1 - modelLast;
            else winner = reqV[1] ? 1 : 0;
            modelLast   = winner;
            modelActive = 1;
            c = cyc;
            expQ.push_back('{c + 1, EV_GNT, winner, dataV[winner]});
            expQ.push_back('{c + 2, EV_REQHI, winner, '0});
            abort = 0;
            repeat (2) begin
                @(negedge clk);
                if (!rstN) abort = 1;
            end
            while (!abort) begin
                @(negedge clk);
                if (!rstN) abort = 1;
                else if (cdcAck) break;
            end
            if (!abort) begin
                expQ.push_back('{cyc + 1, EV_REQLO, winner, '0});
                @(negedge clk);
                if (!rstN) abort = 1;
            end
            while (!abort) begin
                @(negedge clk);
                if (!rstN) abort = 1;
                else if (!cdcAck) break;
            end
            if (abort) begin
                expQ.delete();
                modelLast = 1;
            end else begin
                expQ.push_back('{cyc + 1, EV_DONE, winner, '0});
            end
            modelActive = 0;
        end
    end

    initial begin : monitor
        bit            expG, expHi, expLo, expD;
        int            expId;
        logic [DW-1:0] expData;
        expEv_t        ev;
        forever begin
            @(negedge clk);
            if (!rstN) continue;
            expG = 0; expHi = 0; expLo = 0; expD = 0; expId = 0; expData = '0;
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                ev = expQ.pop_front();
                timeoutFail($sformatf("missedEvent%0d", int'(ev.kind)));
            end
            while (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                ev = expQ.pop_front();
                case (ev.kind)
                    EV_GNT: begin expG = 1; expId = ev.id; expData = ev.data; end
                    EV_REQHI: expHi = 1;
                    EV_REQLO: expLo = 1;
                    default: expD = 1;
                endcase
            end
            if (expG || gnt0 || gnt1 || cdcDataEn || cdcData != '0) begin
                checkOutput("loadStrobes", {gnt0, gnt1, cdcDataEn},
                            expG ? {expId == 0, expId == 1, 1'b1} : 3'b000);
                checkOutput("loadData", cdcData, expData);
                if (expG) checkOutput("loadSrcBusy", {srcId, busy}, {expId[0], 1'b1});
            end
            if (expHi || expLo || cdcReqEn)
                checkOutput("reqReg", {cdcReqEn, cdcReqDi}, expHi ? 2'b11 : (expLo ? 2'b10 : 2'b00));
            if (expD || done) begin
                checkOutput("donePulse", done, expD);
                if (expD) checkOutput("doneBusy", busy, 1'b0);
            end
        end
    end

    task automatic checkResetOutputs(input string name);
        checkOutput(name, {gnt0, gnt1, cdcDataEn, cdcReqEn, cdcReqDi, busy, done, srcId}, 8'h00);
        checkOutput({name, "Data"}, cdcData, '0);
    endtask

    task automatic waitQuiet(input string name, input int budget);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((modelActive || expQ.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) timeoutFail(name);
    endtask

    task automatic setModes(input int m0, input int m1);
        @(negedge clk);
        reqMode[0] = m0;
        reqMode[1] = m1;
    endtask

    initial begin : mainSeq
        int n;
        int grants;
        int dones;
        int doneCyc;
        reqMode[0] = 0;
        reqMode[1] = 0;
        fixedData[0] = 32'hA5A5_0001;
        fixedData[1] = '0;
        reqMode[0] = 3;
        @(negedge clk);
        checkResetOutputs("resetState");
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        waitQuiet("firstTransfer", 100);

        $display("[TB] alternating requesters");
        setModes(0, 0);
        fixedData[0] = 32'd1;
        fixedData[1] = 32'd2;
        setModes(2, 2);
        grants = 0;
        n = 0;
        while (grants < 4 && n < 300) begin
            @(negedge clk);
            if (gnt0 || gnt1) grants++;
            n++;
        end
        if (grants < 4) timeoutFail("alternateGrants");
        setModes(0, 0);
        waitQuiet("alternateDrain", 100);

        $display("[TB] stale acknowledge in idle");
        @(posedge clk);
        #1;
        ackForce = 1'b1;
        ackForceVal = 1'b1;
        fixedData[1] = $urandom;
        reqMode[1] = 3;
        repeat (6) begin
            @(negedge clk);
            checkOutput("staleAckIdle", {busy, cdcDataEn}, 2'b00);
        end
        @(posedge clk);
        #1 ackForce = 1'b0;
        waitQuiet("staleAckDrain", 100);
        setModes(0, 0);

        $display("[TB] acknowledge pulse during load and rise");
        ackForce = 1'b1;
        ackForceVal = 1'b0;
        fixedData[0] = $urandom;
        setModes(3, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 ackForceVal = 1'b1;
        @(posedge clk);
        #1 ackForceVal = 1'b1;
        @(posedge clk);
        #1 ackForceVal = 1'b0;
        repeat (15) @(posedge clk);
        #1 ackForce = 1'b0;
        waitQuiet("pulseDrain", 100);
        setModes(0, 0);

        $display("[TB] reset while waiting for acknowledge");
        ackForce = 1'b1;
        ackForceVal = 1'b0;
        fixedData[0] = $urandom;
        setModes(3, 0);
        n = 0;
        while (!(cdcReqEn && cdcReqDi) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeoutFail("reachRise");
        repeat (3) @(posedge clk);
        #2 rstN = 1'b0;
        #1 checkResetOutputs("asyncReset");
        reqMode[0] = 0;
        ackForce = 1'b0;
        repeat (3) @(posedge clk);
        fixedData[0] = $urandom;
        fixedData[1] = $urandom;
        setModes(3, 3);
        @(posedge clk);
        #1 rstN = 1'b1;
        waitQuiet("postResetDrain", 150);
        setModes(0, 0);

        $display("[TB] back-to-back requester 0, ack delay 3");
        ackSel = 2'd2;
        fixedData[0] = $urandom;
        setModes(2, 0);
        dones = 0;
        doneCyc = -1;
        n = 0;
        while (dones < 3 && n < 400) begin
            @(negedge clk);
            if (gnt0 && doneCyc >= 0) begin
                checkOutput("b2bGap", cyc - doneCyc, 1);
                doneCyc = -1;
            end
            if (done) begin
                dones++;
                doneCyc = cyc;
            end
            n++;
        end
        if (dones < 3) timeoutFail("b2bDones");
        setModes(0, 0);
        waitQuiet("b2bDrain", 100);

        for (int round = 0; round < 3; round++) begin
            $display("[TB] random round %0d", round);
            ackSel = 2'($urandom_range(3));
            setModes(1, 1);
            repeat (400) @(posedge clk);
            setModes(0, 0);
            waitQuiet("randomDrain", 200);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
